// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, instruction field positions,
// reset defaults and the control bundle that selects the next PC.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned DEFAULT_MAX_WAIT = 16;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned JIDX_W     = 26;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic jr;
        logic jal;
        logic branch;
    } pc_ctrl_t;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(XLEN - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection (jr > jal > branch > sequential) plus the
// misalignment flag for register-indirect targets.
module instr_fetch_unit_next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0]   pc,
    input  logic [JIDX_W-1:0] target_idx,
    input  logic [XLEN-1:0]   jr_target,
    input  pc_ctrl_t          ctrl,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [XLEN-1:0]   next_pc,
    output logic              misaligned
);

    logic [XLEN-1:0] jal_target;
    logic [XLEN-1:0] br_target;

    assign pc_plus4   = pc + XLEN'(4);
    assign jal_target = {pc_plus4[XLEN-1:XLEN-4], target_idx, 2'b00};
    assign br_target  = pc_plus4 + branch_offset(target_idx[IMM_W-1:0]);

    always_comb begin
        next_pc = pc_plus4;
        if (ctrl.jr) begin
            next_pc = jr_target;
        end else if (ctrl.jal) begin
            next_pc = jal_target;
        end else if (ctrl.branch) begin
            next_pc = br_target;
        end
    end

    // Only a register target can carry low bits; all other targets are built aligned.
    assign misaligned = ctrl.jr && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the req/ack handshake with instruction memory,
// holds the fetched word for execute and steps the PC when execute advances.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [XLEN-1:0]       imem_addr,
    input  logic                  imem_ack,
    input  logic [XLEN-1:0]       imem_rdata,
    input  logic                  advance,
    input  logic                  branch_taken,
    input  logic                  pc_src_jal,
    input  logic                  pc_src_jr,
    input  logic [XLEN-1:0]       jr_target,
    output logic [XLEN-1:0]       instr,
    output logic                  instr_valid,
    output logic [OPCODE_W-1:0]   opcode,
    output logic [FUNCT_W-1:0]    funct,
    output logic [SHAMT_W-1:0]    shamt,
    output logic [XLEN-1:0]       pc,
    output logic [XLEN-1:0]       pc_plus4,
    output logic                  fetch_err
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [XLEN-1:0]   next_pc;
    logic              misaligned;
    logic              timeout;
    pc_ctrl_t          ctrl;

    logic              take_ack;
    logic              take_advance;
    logic              enter_fetch;
    logic              req_next;
    logic              valid_next;
    logic              err_next;

    assign ctrl      = '{jr: pc_src_jr, jal: pc_src_jal, branch: branch_taken};
    assign timeout   = (wait_cnt == LAST_WAIT);
    assign imem_addr = pc;
    assign opcode    = instr[OPCODE_LSB +: OPCODE_W];
    assign funct     = instr[FUNCT_LSB +: FUNCT_W];
    assign shamt     = instr[SHAMT_LSB +: SHAMT_W];

    instr_fetch_unit_next_pc_calc u_next_pc (
        .pc         (pc),
        .target_idx (instr[JIDX_W-1:0]),
        .jr_target  (jr_target),
        .ctrl       (ctrl),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_START;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an ack in the last allowed wait cycle beats the timeout
    always_comb begin
        state_next = state;
        case (state)
            ST_START: state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next = ST_HOLD;
                end else if (timeout) begin
                    state_next = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    state_next = misaligned ? ST_ERROR : ST_FETCH;
                end
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_ERROR;
        endcase
    end

    // Output/enable decode; handshake flags are registered from the upcoming state
    always_comb begin
        take_ack     = 1'b0;
        take_advance = 1'b0;
        enter_fetch  = 1'b0;
        req_next     = 1'b0;
        valid_next   = 1'b0;
        err_next     = fetch_err;

        take_ack     = (state == ST_FETCH) && imem_ack;
        take_advance = (state == ST_HOLD) && advance && !misaligned;
        enter_fetch  = (state_next == ST_FETCH) && (state != ST_FETCH);
        req_next     = (state_next == ST_FETCH);
        valid_next   = (state_next == ST_HOLD);
        if (state_next == ST_ERROR) begin
            err_next = 1'b1;
        end
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            imem_req    <= req_next;
            instr_valid <= valid_next;
            fetch_err   <= err_next;
            if (take_ack) begin
                instr <= imem_rdata;
            end
            if (take_advance) begin
                pc <= next_pc;
            end
            if (enter_fetch) begin
                wait_cnt <= '0;
            end else if (state == ST_FETCH) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboarded fetch addresses and instruction
// words, covering sequencing, branch/jal/jr priority, timeout boundary and async reset.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned MAX_WAIT = 16;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        advance;
    logic        branch_taken;
    logic        pc_src_jal;
    logic        pc_src_jr;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .advance      (advance),
        .branch_taken (branch_taken),
        .pc_src_jal   (pc_src_jal),
        .pc_src_jr    (pc_src_jr),
        .jr_target    (jr_target),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .funct        (funct),
        .shamt        (shamt),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, then compare its address with the scoreboard.
    task automatic wait_req(input string tag);
        int unsigned n;
        n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, imem_addr, addr_q.pop_front());
    endtask

    // Serve one fetch after `delay` request cycles without ack.
    task automatic do_fetch(input logic [31:0] word, input int unsigned delay, input string tag);
        wait_req(tag);
        repeat (delay) @(negedge clk);
        check({tag, "_req_held"}, 32'(imem_req), 32'd1);
        check({tag, "_valid_pre"}, 32'(instr_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        instr_q.push_back(word);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_req_drop"}, 32'(imem_req), 32'd0);
        check({tag, "_instr"}, instr, instr_q.pop_front());
    endtask

    task automatic do_advance(input logic br, input logic jal, input logic jr,
                              input logic [31:0] tgt, input logic [31:0] exp_next);
        addr_q.push_back(exp_next);
        advance      = 1'b1;
        branch_taken = br;
        pc_src_jal   = jal;
        pc_src_jr    = jr;
        jr_target    = tgt;
        @(negedge clk);
        advance      = 1'b0;
        branch_taken = 1'b0;
        pc_src_jal   = 1'b0;
        pc_src_jr    = 1'b0;
        jr_target    = $urandom;
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_rst_req"}, 32'(imem_req), 32'd0);
        check({tag, "_rst_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_rst_err"}, 32'(fetch_err), 32'd0);
        check({tag, "_rst_pc"}, pc, RESET_PC);
        check({tag, "_rst_instr"}, instr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        advance      = 1'b0;
        branch_taken = 1'b0;
        pc_src_jal   = 1'b0;
        pc_src_jr    = 1'b0;
        jr_target    = '0;

        // 1: reset values, first fetch with a 3-cycle memory
        #1;
        check("t1_rst_req", 32'(imem_req), 32'd0);
        check("t1_rst_valid", 32'(instr_valid), 32'd0);
        check("t1_rst_err", 32'(fetch_err), 32'd0);
        check("t1_rst_pc", pc, RESET_PC);
        check("t1_rst_instr", instr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("t1_start_no_req", 32'(imem_req), 32'd0);
        addr_q.push_back(RESET_PC);
        do_fetch(32'h2008_0005, 3, "t1_addi");
        check("t1_opcode", 32'(opcode), 32'h08);
        check("t1_funct", 32'(funct), 32'h05);
        check("t1_shamt", 32'(shamt), 32'h00);
        check("t1_pc", pc, 32'h0);
        check("t1_pc_plus4", pc_plus4, 32'h4);

        // 2: sequential, then taken beq with offset -1 loops back to itself
        do_advance(1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        do_fetch(32'h1000_FFFF, 1, "t2_beq");
        check("t2_pc", pc, 32'h4);
        do_advance(1'b1, 1'b0, 1'b0, 32'h0, 32'h4);
        do_fetch(32'h0000_0000, 0, "t2_nop");
        do_advance(1'b0, 1'b0, 1'b0, 32'h0, 32'h8);

        // 3: jal wins over branch_taken; fields stay stable while held
        do_fetch(32'h0C00_0010, 2, "t3_jal");
        check("t3_pc", pc, 32'h8);
        check("t3_pc_plus4", pc_plus4, 32'hC);
        repeat (3) @(negedge clk);
        check("t3_hold_instr", instr, 32'h0C00_0010);
        check("t3_hold_valid", 32'(instr_valid), 32'd1);
        check("t3_hold_req", 32'(imem_req), 32'd0);
        do_advance(1'b1, 1'b1, 1'b0, 32'h0, 32'h40);

        // 4: jr beats jal; advance during FETCH is ignored; misaligned jr is fatal
        do_fetch(32'h03E0_0008, 0, "t4_jr_a");
        do_advance(1'b0, 1'b1, 1'b1, 32'h100, 32'h100);
        advance      = 1'b1;
        branch_taken = 1'b1;
        @(negedge clk);
        advance      = 1'b0;
        branch_taken = 1'b0;
        check("t4_fetch_adv_req", 32'(imem_req), 32'd1);
        check("t4_fetch_adv_pc", pc, 32'h100);
        do_fetch(32'h03E0_0008, 0, "t4_jr_b");
        advance   = 1'b1;
        pc_src_jr = 1'b1;
        jr_target = 32'h102;
        @(negedge clk);
        advance   = 1'b0;
        pc_src_jr = 1'b0;
        check("t4_mis_err", 32'(fetch_err), 32'd1);
        check("t4_mis_req", 32'(imem_req), 32'd0);
        check("t4_mis_valid", 32'(instr_valid), 32'd0);
        check("t4_mis_pc", pc, 32'h100);
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        check("t4_err_sticky", 32'(fetch_err), 32'd1);
        check("t4_err_no_req", 32'(imem_req), 32'd0);
        check("t4_err_no_valid", 32'(instr_valid), 32'd0);

        // 5: ack on the last allowed cycle, then a real timeout
        pulse_reset("t5");
        addr_q.push_back(RESET_PC);
        do_fetch(32'h2008_0005, MAX_WAIT - 1, "t5_last_ack");
        check("t5_last_ack_err", 32'(fetch_err), 32'd0);
        do_advance(1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        wait_req("t5_to");
        repeat (MAX_WAIT - 1) @(negedge clk);
        check("t5_to_err_pre", 32'(fetch_err), 32'd0);
        check("t5_to_req_pre", 32'(imem_req), 32'd1);
        @(negedge clk);
        check("t5_to_err", 32'(fetch_err), 32'd1);
        check("t5_to_req", 32'(imem_req), 32'd0);

        // 6: reset mid-FETCH with ack overlapping reset and its release
        pulse_reset("t6a");
        addr_q.push_back(RESET_PC);
        wait_req("t6_pre");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("t6_mid_req", 32'(imem_req), 32'd0);
        check("t6_mid_valid", 32'(instr_valid), 32'd0);
        check("t6_mid_pc", pc, RESET_PC);
        check("t6_mid_instr", instr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("t6_rel_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        check("t6_late_ack_valid", 32'(instr_valid), 32'd0);
        check("t6_late_ack_instr", instr, 32'd0);
        addr_q.push_back(RESET_PC);
        do_fetch(32'h2008_0005, 1, "t6_restart");

        // Address wrap: jr to the top word, then sequential wraps to 0
        do_advance(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0000, 0, "t6_top");
        check("t6_top_plus4", pc_plus4, 32'h0);
        do_advance(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(32'h2008_0005, 0, "t6_wrap");
        check("t6_wrap_pc", pc, 32'h0);
        check("t6_wrap_err", 32'(fetch_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
